// File: rtl/life_game_stepper.sv
// Generation engine and cell-port arbiter for the double-buffered 64x48 life world.
// Reads the displayed buffer row by row, writes B3/S23 results to the hidden buffer, then flips.
module life_game_stepper #(
  parameter int ROWS        = 48,
  parameter int STEP_PERIOD = 1000000,
  parameter bit WRAP        = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        cpu_write,
  input  logic [6:0]  cpu_address,
  input  logic [31:0] cpu_data_in,
  output logic        cpu_wait,
  output logic        cell_write,
  output logic [6:0]  cell_address,
  output logic [31:0] cell_data_in,
  input  logic [31:0] cell_data_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] generation
);

  localparam int             CW        = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [CW-1:0]  TICK_LAST = CW'(STEP_PERIOD - 1);
  localparam logic [5:0]     LAST_ROW  = 6'(ROWS - 1);
  localparam logic [6:0]     SEL_ADDR  = 7'd127;

  typedef enum logic [3:0] {
    S_SYNC, S_IDLE, S_RA0, S_RA1, S_RC0, S_RC1,
    S_RB0, S_RB1, S_W0, S_W1, S_FLIP
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_tick_cnt;
  logic          r_pending;
  logic          r_index;
  logic [15:0]   r_generation;
  logic [5:0]    r_y;
  logic [63:0]   r_a;
  logic [63:0]   r_c;
  logic [63:0]   r_b;
  logic          w_tick;
  logic          w_req;
  logic [5:0]    w_y_below;
  logic [63:0]   w_next;

  function automatic logic [63:0] life_next(input logic [63:0] a, input logic [63:0] c,
                                            input logic [63:0] b);
    logic [63:0] nxt;
    logic [3:0]  cnt;
    logic        has_l;
    logic        has_r;
    for (int x = 0; x < 64; x++) begin
      has_l = WRAP || (x != 0);
      has_r = WRAP || (x != 63);
      cnt   = {3'd0, a[x]} + {3'd0, b[x]};
      if (has_l) begin
        cnt = cnt + {3'd0, a[(x+63)%64]} + {3'd0, c[(x+63)%64]} + {3'd0, b[(x+63)%64]};
      end else begin
        cnt = cnt;
      end
      if (has_r) begin
        cnt = cnt + {3'd0, a[(x+1)%64]} + {3'd0, c[(x+1)%64]} + {3'd0, b[(x+1)%64]};
      end else begin
        cnt = cnt;
      end
      nxt[x] = (cnt == 4'd3) | (c[x] & (cnt == 4'd2));
    end
    return nxt;
  endfunction

  assign w_tick     = run & (r_tick_cnt == TICK_LAST);
  assign w_req      = step | w_tick;
  assign w_y_below  = (r_y == LAST_ROW) ? 6'd0 : r_y + 6'd1;
  assign w_next     = life_next(r_a, r_c, r_b);
  assign busy       = ~reset & (r_state != S_IDLE);
  assign done       = ~reset & (r_state == S_FLIP);
  assign cpu_wait   = busy;
  assign generation = r_generation;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (!run || r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CW'(1);
    end
  end

  // Requests merge; IDLE always consumes whatever is pending as it launches a step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_pending <= 1'b0;
    end else if (w_req) begin
      r_pending <= 1'b1;
    end else begin
      r_pending <= r_pending;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_SYNC:  w_state_next = S_IDLE;
      S_IDLE:  w_state_next = (r_pending | w_req) ? S_RA0 : S_IDLE;
      S_RA0:   w_state_next = S_RA1;
      S_RA1:   w_state_next = S_RC0;
      S_RC0:   w_state_next = S_RC1;
      S_RC1:   w_state_next = S_RB0;
      S_RB0:   w_state_next = S_RB1;
      S_RB1:   w_state_next = S_W0;
      S_W0:    w_state_next = S_W1;
      S_W1:    w_state_next = (r_y == LAST_ROW) ? S_FLIP : S_RB0;
      S_FLIP:  w_state_next = S_IDLE;
      default: w_state_next = S_SYNC;
    endcase
  end

  // Row window A/C/B, row counter, buffer index and generation count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a          <= 64'd0;
      r_c          <= 64'd0;
      r_b          <= 64'd0;
      r_y          <= 6'd0;
      r_index      <= 1'b0;
      r_generation <= 16'd0;
    end else begin
      case (r_state)
        S_SYNC: begin
          r_index <= 1'b0;
          r_y     <= 6'd0;
        end
        S_IDLE: begin
          r_y <= 6'd0;
          if (cpu_write && cpu_address == SEL_ADDR) begin
            r_index <= cpu_data_in[0];
          end
        end
        S_RA0:  r_a[31:0]  <= WRAP ? cell_data_out : 32'd0;
        S_RA1:  r_a[63:32] <= WRAP ? cell_data_out : 32'd0;
        S_RC0:  r_c[31:0]  <= cell_data_out;
        S_RC1:  r_c[63:32] <= cell_data_out;
        S_RB0:  r_b[31:0]  <= (WRAP || r_y != LAST_ROW) ? cell_data_out : 32'd0;
        S_RB1:  r_b[63:32] <= (WRAP || r_y != LAST_ROW) ? cell_data_out : 32'd0;
        S_W1: begin
          r_a <= r_c;
          r_c <= r_b;
          if (r_y != LAST_ROW) begin
            r_y <= r_y + 6'd1;
          end
        end
        S_FLIP: begin
          r_index      <= ~r_index;
          r_generation <= r_generation + 16'd1;
        end
        default: r_y <= r_y;
      endcase
    end
  end

  // Cell port: CPU passthrough only in IDLE; held at zero while reset is asserted.
  always_comb begin
    cell_write   = 1'b0;
    cell_address = 7'd0;
    cell_data_in = 32'd0;
    if (reset) begin
      cell_write = 1'b0;
    end else begin
      case (r_state)
        S_SYNC: begin
          cell_write   = 1'b1;
          cell_address = SEL_ADDR;
        end
        S_IDLE: begin
          cell_write   = cpu_write;
          cell_address = cpu_address;
          cell_data_in = cpu_data_in;
        end
        S_RA0:  cell_address = {LAST_ROW, 1'b0};
        S_RA1:  cell_address = {LAST_ROW, 1'b1};
        S_RC0:  cell_address = 7'd0;
        S_RC1:  cell_address = 7'd1;
        S_RB0:  cell_address = {w_y_below, 1'b0};
        S_RB1:  cell_address = {w_y_below, 1'b1};
        S_W0: begin
          cell_write   = 1'b1;
          cell_address = {r_y, 1'b0};
          cell_data_in = w_next[31:0];
        end
        S_W1: begin
          cell_write   = 1'b1;
          cell_address = {r_y, 1'b1};
          cell_data_in = w_next[63:32];
        end
        S_FLIP: begin
          cell_write   = 1'b1;
          cell_address = SEL_ADDR;
          cell_data_in = {31'd0, ~r_index};
        end
        default: cell_write = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_life_game_stepper.sv
// Bench for life_game_stepper: models the double-buffered world device and checks
// each generation against a cell-by-cell B3/S23 reference on a toroidal 64x48 grid.
module tb_life_game_stepper;

  localparam int ROWS   = 48;
  localparam int PERIOD = 300;

  logic        clock = 1'b0;
  logic        reset, run, step, cpu_write;
  logic [6:0]  cpu_address;
  logic [31:0] cpu_data_in;
  logic        cpu_wait, cell_write;
  logic [6:0]  cell_address;
  logic [31:0] cell_data_in, cell_data_out;
  logic        busy, done;
  logic [15:0] generation;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        exp_sel;
  logic [15:0] exp_gen;
  bit          mdl [0:ROWS-1][0:63];
  logic [31:0] dev_mem [0:1][0:95];
  logic        dev_sel;

  always #5 clock = ~clock;

  life_game_stepper #(.ROWS(ROWS), .STEP_PERIOD(PERIOD), .WRAP(1'b1)) dut (
    .clock(clock), .reset(reset), .run(run), .step(step),
    .cpu_write(cpu_write), .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
    .cpu_wait(cpu_wait), .cell_write(cell_write), .cell_address(cell_address),
    .cell_data_in(cell_data_in), .cell_data_out(cell_data_out),
    .busy(busy), .done(done), .generation(generation)
  );

  // Device: reads show the displayed buffer, writes land in the hidden one, 127 selects.
  always_comb cell_data_out = (cell_address < 7'd96) ? dev_mem[dev_sel][int'(cell_address)] : 32'd0;

  always @(posedge clock) begin
    if (cell_write === 1'b1) begin
      if (cell_address == 7'd127) dev_sel <= cell_data_in[0];
      else if (cell_address < 7'd96) dev_mem[~dev_sel][int'(cell_address)] <= cell_data_in;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mdl_word(input int y, input int w);
    logic [31:0] v;
    for (int b = 0; b < 32; b++) v[b] = mdl[y][w*32+b];
    return v;
  endfunction

  function automatic int world_diff();
    int n = 0;
    for (int y = 0; y < ROWS; y++)
      for (int w = 0; w < 2; w++)
        if (dev_mem[dev_sel][y*2+w] !== mdl_word(y, w)) n++;
    return n;
  endfunction

  task automatic model_step();
    bit nx [0:ROWS-1][0:63];
    int cnt;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < 64; x++) begin
        cnt = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy != 0 || dx != 0) cnt += int'(mdl[(y+dy+ROWS)%ROWS][(x+dx+64)%64]);
        nx[y][x] = (cnt == 3) || (mdl[y][x] && cnt == 2);
      end
    mdl = nx;
    exp_sel = ~exp_sel;
    exp_gen = exp_gen + 16'd1;
  endtask

  task automatic clear_world();
    for (int y = 0; y < ROWS; y++) for (int x = 0; x < 64; x++) mdl[y][x] = 1'b0;
  endtask

  task automatic random_world();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < 64; x++) mdl[y][x] = ($urandom_range(0, 2) == 0);
  endtask

  task automatic cpu_wr(input logic [6:0] a, input logic [31:0] d);
    cpu_address = a; cpu_data_in = d; cpu_write = 1'b1;
    cyc();
    cpu_write = 1'b0;
  endtask

  task automatic load_world();
    for (int y = 0; y < ROWS; y++)
      for (int w = 0; w < 2; w++) cpu_wr(7'(y*2+w), mdl_word(y, w));
    cpu_wr(7'd127, {31'd0, ~exp_sel});
    exp_sel = ~exp_sel;
  endtask

  task automatic run_gen(output int k, output logic [39:0] flip_obs, output logic busy_after);
    step = 1'b1;
    cyc();
    step = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 400) begin cyc(); k++; end
    flip_obs = {cell_write, cell_address, cell_data_in};
    cyc();
    busy_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; cpu_write = 1'b0;
    cpu_address = 7'd0; cpu_data_in = 32'd0;
    cyc(); cyc();
    n_cmp++;
    if ({cell_write, cell_address, cell_data_in, busy, done, generation, cpu_wait} !== 59'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got w=%b a=%0d d=%h busy=%b done=%b gen=%0d wait=%b required all 0",
               cell_write, cell_address, cell_data_in, busy, done, generation, cpu_wait);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({cell_write, cell_address, cell_data_in, busy} !== {1'b1, 7'd127, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_sync got w=%b a=%0d d=%h busy=%b required 1/127/0/1",
               cell_write, cell_address, cell_data_in, busy);
    end
    cyc();
    n_cmp++;
    if ({busy, cpu_wait, generation} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_idle got busy=%b wait=%b gen=%0d required 0/0/0", busy, cpu_wait, generation);
    end
    exp_sel = 1'b0; exp_gen = 16'd0;
  endtask

  task automatic test_blinker();
    int k; logic [39:0] fo; logic ba;
    logic [39:0] exp_flip;
    clear_world();
    mdl[10][31] = 1'b1; mdl[10][32] = 1'b1; mdl[10][33] = 1'b1;
    load_world();
    exp_flip = {1'b1, 7'd127, 31'd0, ~exp_sel};
    run_gen(k, fo, ba);
    model_step();
    n_cmp++;
    if (fo !== exp_flip) begin
      n_fail++; $display("FAIL blinker_flip got %h required %h", fo, exp_flip);
    end
    for (int y = 9; y <= 11; y++) begin
      n_cmp++;
      if ({dev_mem[dev_sel][y*2+1], dev_mem[dev_sel][y*2]} !== {32'h1, 32'h0}) begin
        n_fail++;
        $display("FAIL blinker_row%0d got w1=%h w0=%h required 00000001/00000000",
                 y, dev_mem[dev_sel][y*2+1], dev_mem[dev_sel][y*2]);
      end
    end
    n_cmp++;
    if (world_diff() !== 0) begin
      n_fail++; $display("FAIL blinker_world got %0d bad words required 0", world_diff());
    end
    n_cmp++;
    if (generation !== exp_gen) begin
      n_fail++; $display("FAIL blinker_gen got %0d required %0d", generation, exp_gen);
    end
  endtask

  task automatic test_wrap();
    int k; logic [39:0] fo; logic ba;
    clear_world();
    mdl[47][0] = 1'b1; mdl[0][0] = 1'b1; mdl[1][0] = 1'b1;
    load_world();
    run_gen(k, fo, ba);
    model_step();
    n_cmp++;
    if ({dev_mem[dev_sel][1], dev_mem[dev_sel][0]} !== {32'h80000000, 32'h00000003}) begin
      n_fail++;
      $display("FAIL wrap_row0 got w1=%h w0=%h required 80000000/00000003",
               dev_mem[dev_sel][1], dev_mem[dev_sel][0]);
    end
    n_cmp++;
    if ({dev_mem[dev_sel][94], dev_mem[dev_sel][95], dev_mem[dev_sel][2], dev_mem[dev_sel][3]} !== 128'd0) begin
      n_fail++; $display("FAIL wrap_rows47_1 got nonzero required 0");
    end
    n_cmp++;
    if (world_diff() !== 0) begin
      n_fail++; $display("FAIL wrap_world got %0d bad words required 0", world_diff());
    end
  endtask

  task automatic test_timing();
    logic [31:0] snap [0:95];
    logic        old_sel;
    int          k, low, chg;
    logic [39:0] fo;
    logic [39:0] exp_flip;
    random_world();
    load_world();
    for (int i = 0; i < 96; i++) snap[i] = dev_mem[dev_sel][i];
    old_sel  = dev_sel;
    exp_flip = {1'b1, 7'd127, 31'd0, ~exp_sel};
    step = 1'b1;
    cyc();
    step = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL timing_busy_rise got %b required 1", busy); end
    k = 1; low = 0;
    while (done !== 1'b1 && k < 400) begin
      cyc(); k++;
      if (busy !== 1'b1) low++;
    end
    fo = {cell_write, cell_address, cell_data_in};
    chg = 0;
    for (int i = 0; i < 96; i++) if (dev_mem[dev_sel][i] !== snap[i]) chg++;
    n_cmp++;
    if (k !== 197) begin n_fail++; $display("FAIL timing_latency got %0d required 197", k); end
    n_cmp++;
    if (low !== 0) begin n_fail++; $display("FAIL timing_busy_hold got %0d low cycles required 0", low); end
    n_cmp++;
    if (chg !== 0 || dev_sel !== old_sel) begin
      n_fail++; $display("FAIL timing_display_stable got %0d changed words sel=%b required 0 sel=%b", chg, dev_sel, old_sel);
    end
    n_cmp++;
    if (fo !== exp_flip) begin n_fail++; $display("FAIL timing_flip got %h required %h", fo, exp_flip); end
    cyc();
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL timing_busy_fall got %b required 0", busy); end
    model_step();
    n_cmp++;
    if (world_diff() !== 0) begin
      n_fail++; $display("FAIL timing_world got %0d bad words required 0", world_diff());
    end
  endtask

  task automatic test_arbitration();
    int k;
    logic [39:0] fo;
    random_world();
    if (exp_sel == 1'b0) begin
      cpu_wr(7'd127, 32'd1);
      exp_sel = 1'b1;
    end
    load_world();
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc(); cyc();
    k = 3;
    cpu_write = 1'b1; cpu_address = 7'd10; cpu_data_in = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if ({cpu_wait, cell_write} !== 2'b10) begin
      n_fail++; $display("FAIL arb_lockout got wait=%b write=%b required 1/0", cpu_wait, cell_write);
    end
    @(posedge clock); #1;
    cpu_write = 1'b0;
    k = 4;
    while (done !== 1'b1 && k < 400) begin cyc(); k++; end
    fo = {cell_write, cell_address, cell_data_in};
    n_cmp++;
    if (fo !== {1'b1, 7'd127, 32'd1}) begin
      n_fail++; $display("FAIL arb_flip_data got %h required %h", fo, {1'b1, 7'd127, 32'd1});
    end
    cyc();
    model_step();
    n_cmp++;
    if (world_diff() !== 0 || dev_sel !== exp_sel) begin
      n_fail++; $display("FAIL arb_world got %0d bad words sel=%b required 0 sel=%b", world_diff(), dev_sel, exp_sel);
    end
  endtask

  task automatic test_periodic();
    int pulses = 0;
    random_world();
    load_world();
    run = 1'b1;
    for (int i = 0; i < 1000; i++) begin cyc(); if (done === 1'b1) pulses++; end
    run = 1'b0;
    for (int i = 0; i < 300; i++) begin cyc(); if (done === 1'b1) pulses++; end
    n_cmp++;
    if (pulses !== 3) begin n_fail++; $display("FAIL periodic_pulses got %0d required 3", pulses); end
    for (int i = 0; i < 3; i++) model_step();
    n_cmp++;
    if (world_diff() !== 0 || generation !== exp_gen) begin
      n_fail++; $display("FAIL periodic_world got %0d bad words gen=%0d required 0 gen=%0d", world_diff(), generation, exp_gen);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int first = -1, second = -1;
    random_world();
    load_world();
    step = 1'b1; cyc(); step = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    step = 1'b1; cyc(); step = 1'b0;
    for (int i = 0; i < 500; i++) begin
      cyc();
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) first = i; else second = i;
      end
    end
    n_cmp++;
    if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulses got %0d required 2", pulses); end
    n_cmp++;
    if (second - first !== 198) begin
      n_fail++; $display("FAIL b2b_gap got %0d required 198", second - first);
    end
    model_step(); model_step();
    n_cmp++;
    if (world_diff() !== 0) begin
      n_fail++; $display("FAIL b2b_world got %0d bad words required 0", world_diff());
    end
  endtask

  task automatic test_reset_mid();
    int k; logic [39:0] fo; logic ba;
    random_world();
    load_world();
    step = 1'b1; cyc(); step = 1'b0;
    for (int i = 1; i < 85; i++) cyc();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({cell_write, cell_address, cell_data_in, busy, done, generation, cpu_wait} !== 59'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs got w=%b a=%0d d=%h busy=%b done=%b gen=%0d wait=%b required all 0",
               cell_write, cell_address, cell_data_in, busy, done, generation, cpu_wait);
    end
    cyc();
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({cell_write, cell_address, cell_data_in} !== {1'b1, 7'd127, 32'd0}) begin
      n_fail++; $display("FAIL midreset_sync got w=%b a=%0d d=%h required 1/127/0", cell_write, cell_address, cell_data_in);
    end
    cyc();
    n_cmp++;
    if ({busy, generation} !== 17'd0 || dev_sel !== 1'b0) begin
      n_fail++; $display("FAIL midreset_idle got busy=%b gen=%0d sel=%b required 0/0/0", busy, generation, dev_sel);
    end
    exp_sel = 1'b0; exp_gen = 16'd0;
    random_world();
    load_world();
    run_gen(k, fo, ba);
    model_step();
    n_cmp++;
    if (world_diff() !== 0 || generation !== exp_gen || fo !== {1'b1, 7'd127, 32'd0}) begin
      n_fail++; $display("FAIL postreset_step got %0d bad words gen=%0d flip=%h required 0 gen=%0d flip=%h",
                         world_diff(), generation, fo, exp_gen, {1'b1, 7'd127, 32'd0});
    end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_wrap();
    test_timing();
    test_arbitration();
    test_periodic();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
